note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
- Bus-mapped controller that schedules a queue of notes into the buzzer tone generator.
- Software pushes {duration, freq} words into a note FIFO. The block pops them in order and drives the tone generator's frequency divisor and enable for exactly duration×tick cycles each. It raises an interrupt when the queue drains.
- Sits in the user peripheral space beside the tone generator and timer; its freq_o/tone_en_o feed the tone divider.

Parameters:
- DEPTH, 8, note FIFO entries (power of two, ≥2)
- TICK_RESET, 50000, reset value of TICK register (cycles per duration unit)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- cs_i  in  1  device select
- read_i  in  1  bus read strobe
- write_i  in  1  bus write strobe
- address_i  in  4  byte address within block (word-aligned, [3:2] decoded)
- data_in  in  32  store data
- data_out  out  32  load data
- freq_o  out  16  divisor to tone generator (0 = silent)
- tone_en_o  out  1  tone generator enable
- busy_o  out  1  high in LOAD or PLAY
- irq_o  out  1  level interrupt request

Behaviour:
- One clock domain: clk. Reset is synchronous and active-low, on the port named reset.
- Reset values: data_out=0, freq_o=0, tone_en_o=0, busy_o=0, irq_o=0. Also: FIFO empty, CTRL=0, TICK=TICK_RESET, sticky flags=0, state=IDLE.
- Register map, word offsets [3:2]:
  - 0 NOTE (W): push {dur[31:16], freq[15:0]}.
  - 1 CTRL (R/W): bit0 enable, bit1 irq_en, bit2 flush (self-clearing, reads 0).
  - 2 STATUS (R): bit0 overflow, bit1 done, bit2 empty, bit3 full, bit4 busy, [15:8] count. Writing 1 to bit0 or bit1 clears that flag (W1C).
  - 3 TICK (R/W): 32-bit cycles per duration unit; a write of 0 is stored as 1.
  - NOTE reads return 0.
- Reads: address_i[3:2] latched when cs_i&&read_i. data_out is valid the following cycle from the latched address, and is 0 when no read is selected.
- Push when full: word dropped, overflow set, FIFO unchanged.
- Push and pop in the same cycle: both occur, count unchanged.
- FSM:
  - IDLE: freq_o=0, tone_en_o=0. Goes to LOAD when enable && !empty.
  - LOAD (1 cycle): pop head into freq_r/dur_r; prescaler=TICK-1; tone_en_o=0. If dur=0, skip the note: go to LOAD if enable && !empty, else IDLE. Otherwise go to PLAY.
  - PLAY: freq_o=freq_r; tone_en_o=(freq_r!=0), so freq 0 is a timed rest. The prescaler counts down to 0, then reloads TICK-1 and decrements dur_r. When dur_r reaches 0 on a tick, PLAY ends after exactly dur×TICK cycles. Next state is LOAD if enable && !empty, else IDLE.
- Note spacing: each consecutive note adds a 1-cycle silent LOAD gap.
- done flag: set on every transition into IDLE from LOAD/PLAY. irq_o = irq_en && done.
- enable cleared mid-note: next cycle goes to IDLE with the tone off. The current note is discarded, the FIFO is kept, and done is NOT set.
- flush: FIFO emptied and FSM to IDLE next cycle, overriding any push in the same cycle. Flags unchanged.
- A TICK write mid-note takes effect at the next prescaler reload.
- Duration arithmetic: 16-bit dur, 32-bit prescaler, no wrap. The maximum note is 65535×TICK cycles.

Decomposition:
- Package note_seq_pkg holds:
  - register offset constants (REG_NOTE=0, REG_CTRL=1, REG_STATUS=2, REG_TICK=3);
  - state enum {IDLE, LOAD, PLAY};
  - packed note_t {dur[15:0], freq[15:0]}.
- Sub-module note_fifo: synchronous FIFO parameterised by DEPTH. It has push, pop, flush, full, empty and count, and shows the head word in the same cycle (first-word fall-through).

Test Plan:
- Single note:
  - Stimulus: TICK=4, push 0x0003_0010, CTRL=0x3.
  - Response: after LOAD, freq_o=0x0010 and tone_en_o=1 for exactly 12 cycles, then IDLE. done=1, irq_o=1.
  - Writing STATUS=0x2 drops irq_o.
- Back-to-back notes:
  - Stimulus: TICK=2, push 0x0002_0020, 0x0001_0000, 0x0002_0030, enable.
  - Response: 0x20 tone for 4 cycles, 1-cycle gap, 2-cycle rest (tone_en_o=0), 1-cycle gap, 0x30 tone for 4 cycles, done.
- Overflow:
  - Stimulus: DEPTH+2 pushes with enable=0.
  - Response: STATUS reads full=1, count=8, overflow=1. Playback then plays only the first 8 notes in order.
- Zero duration:
  - Stimulus: push 0x0000_0055 then 0x0001_0011 with TICK=3.
  - Response: 0x55 never appears on freq_o; 0x11 plays 3 cycles.
- Abort and flush:
  - Enable cleared mid-note: tone off next cycle, remaining count intact, done=0.
  - Flush with 3 queued notes: empty=1, count=0.
  - Reset asserted mid-PLAY: all outputs 0 next cycle.
- Simultaneous push/pop plus TICK=0:
  - Push on the LOAD pop cycle: count unchanged.
  - TICK write of 0 reads back as 1 and a dur=2 note lasts 2 cycles.

Source files
------------

// File: rtl/note_seq_pkg.sv
// Shared types and register offsets for the note sequencer.
package note_seq_pkg;
  localparam logic [1:0] REG_NOTE   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_TICK   = 2'd3;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_e;

  typedef struct packed {
    logic [15:0] dur;
    logic [15:0] freq;
  } note_t;
endpackage

// File: rtl/note_sequencer_if.sv
// Register bus between the CPU side (master) and the sequencer (slave).
interface note_sequencer_if;
  logic        cs_i;
  logic        read_i;
  logic        write_i;
  logic [3:0]  address_i;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (output cs_i, read_i, write_i, address_i, data_in, input data_out);
  modport slave  (input cs_i, read_i, write_i, address_i, data_in, output data_out);
endinterface

// File: rtl/note_fifo.sv
// First-word-fall-through note FIFO; a push into a full FIFO is dropped, flush wins over push/pop.
module note_fifo
  import note_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  note_t         wdata_i,
  output note_t         head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  note_t         mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rptr_q];
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end
endmodule

// File: rtl/note_sequencer.sv
// Bus-mapped note sequencer: pops {dur,freq} notes and drives the tone divider
// for dur*TICK cycles each, with a 1-cycle silent LOAD between notes.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int          DEPTH      = 8,
  parameter logic [31:0] TICK_RESET = 32'd50000
) (
  input  logic               clk,
  input  logic               reset,
  note_sequencer_if.slave    bus,
  output logic [15:0]        freq_o,
  output logic               tone_en_o,
  output logic               busy_o,
  output logic               irq_o
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_e        state_q, state_d;
  logic          en_q, en_d, irq_en_q, irq_en_d, ovf_q, ovf_d, done_q, done_d;
  logic [31:0]   tick_q, tick_d, presc_q, presc_d, rdata;
  logic [15:0]   freq_q, freq_d, dur_q, dur_d;
  logic          rd_vld_q;
  logic [1:0]    rd_addr_q;
  logic          wr_note, wr_ctrl, wr_stat, wr_tick, flush, pop, push_acc, more_d;
  logic          set_done, full, empty;
  logic [CW-1:0] count;
  note_t         head;
  logic          unused_addr;

  assign unused_addr = ^bus.address_i[1:0];
  assign wr_note  = bus.cs_i && bus.write_i && (bus.address_i[3:2] == REG_NOTE);
  assign wr_ctrl  = bus.cs_i && bus.write_i && (bus.address_i[3:2] == REG_CTRL);
  assign wr_stat  = bus.cs_i && bus.write_i && (bus.address_i[3:2] == REG_STATUS);
  assign wr_tick  = bus.cs_i && bus.write_i && (bus.address_i[3:2] == REG_TICK);
  assign flush    = wr_ctrl && bus.data_in[2];
  assign pop      = (state_q == LOAD) && !flush;
  assign push_acc = wr_note && !full && !flush;
  // FIFO holds at least one note once this cycle's push/pop have landed
  assign more_d   = (count > CW'(pop)) || push_acc;

  note_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (wr_note),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (note_t'(bus.data_in)),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    freq_d   = freq_q;
    dur_d    = dur_q;
    presc_d  = presc_q;
    set_done = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (en_d && more_d) state_d = LOAD;
        LOAD: begin
          freq_d  = head.freq;
          dur_d   = head.dur;
          presc_d = tick_q - 32'd1;
          if (!en_d) state_d = IDLE;
          else if (head.dur != 16'd0) state_d = PLAY;
          else if (more_d) state_d = LOAD;
          else begin
            state_d  = IDLE;
            set_done = 1'b1;
          end
        end
        PLAY: begin
          if (!en_d) begin
            state_d = IDLE;
          end else if (presc_q != 32'd0) begin
            presc_d = presc_q - 32'd1;
          end else begin
            // reload picks up any TICK written during the previous unit
            presc_d = tick_q - 32'd1;
            dur_d   = dur_q - 16'd1;
            if (dur_q == 16'd1) begin
              if (more_d) state_d = LOAD;
              else begin
                state_d  = IDLE;
                set_done = 1'b1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    en_d     = wr_ctrl ? bus.data_in[0] : en_q;
    irq_en_d = wr_ctrl ? bus.data_in[1] : irq_en_q;
    tick_d   = tick_q;
    ovf_d    = ovf_q;
    done_d   = done_q;
    if (wr_tick) tick_d = (bus.data_in == 32'd0) ? 32'd1 : bus.data_in;
    if (wr_stat && bus.data_in[0]) ovf_d = 1'b0;
    if (wr_stat && bus.data_in[1]) done_d = 1'b0;
    if (wr_note && full) ovf_d = 1'b1;
    if (set_done) done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      tick_q    <= TICK_RESET;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      freq_q    <= '0;
      dur_q     <= '0;
      presc_q   <= '0;
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      en_q      <= en_d;
      irq_en_q  <= irq_en_d;
      tick_q    <= tick_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      freq_q    <= freq_d;
      dur_q     <= dur_d;
      presc_q   <= presc_d;
      rd_vld_q  <= bus.cs_i && bus.read_i;
      rd_addr_q <= bus.address_i[3:2];
    end
  end

  assign freq_o    = (state_q == PLAY) ? freq_q : 16'd0;
  assign tone_en_o = (state_q == PLAY) && (freq_q != 16'd0);
  assign busy_o    = (state_q != IDLE);
  assign irq_o     = irq_en_q && done_q;

  always_comb begin
    rdata = '0;
    if (rd_vld_q) begin
      unique case (rd_addr_q)
        REG_CTRL:   rdata = {30'd0, irq_en_q, en_q};
        REG_STATUS: rdata = {16'd0, 8'(count), 3'd0, busy_o, full, empty, done_q, ovf_q};
        REG_TICK:   rdata = tick_q;
        default:    rdata = '0;
      endcase
    end
  end

  assign bus.data_out = rdata;
endmodule

// File: tb/tb_note_sequencer.sv
// Randomised and directed checks of note_sequencer against a queue-based reference model.
module tb_note_sequencer;
  import note_seq_pkg::*;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] freq_o;
  logic        tone_en_o, busy_o, irq_o;

  note_sequencer_if bus();

  note_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .freq_o(freq_o), .tone_en_o(tone_en_o), .busy_o(busy_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endfunction

  // Reference model: queue of notes, current note as units left / cycles left in unit.
  note_t       mq[$];
  bit          m_valid = 0, m_en, m_ien, m_ovf, m_done, m_rdv;
  bit [1:0]    m_rda;
  int unsigned m_tick, m_freq, m_units, m_cyc;
  int          m_st;  // 0 idle, 1 load, 2 play

  always @(posedge clk) begin : model
    bit [1:0]    a;
    bit          wn, wc, ws, wt, fl, nen, more;
    note_t       hd;
    int unsigned old_tick;
    int          sz;
    a  = bus.address_i[3:2];
    wn = bus.cs_i && bus.write_i && a == 2'd0;
    wc = bus.cs_i && bus.write_i && a == 2'd1;
    ws = bus.cs_i && bus.write_i && a == 2'd2;
    wt = bus.cs_i && bus.write_i && a == 2'd3;
    if (!reset) begin
      mq.delete();
      m_en = 0; m_ien = 0; m_ovf = 0; m_done = 0; m_rdv = 0; m_rda = 0;
      m_tick = 50000; m_st = 0; m_freq = 0; m_units = 0; m_cyc = 0;
      m_valid = 1;
    end else begin
      fl       = wc && bus.data_in[2];
      nen      = wc ? bus.data_in[0] : m_en;
      old_tick = m_tick;
      sz       = mq.size();
      hd       = (sz > 0) ? mq[0] : '0;
      if (ws && bus.data_in[0]) m_ovf = 0;
      if (ws && bus.data_in[1]) m_done = 0;
      if (wn && sz >= DEPTH) m_ovf = 1;
      if (wt) m_tick = (bus.data_in == 0) ? 1 : bus.data_in;
      if (wc) begin m_en = bus.data_in[0]; m_ien = bus.data_in[1]; end
      if (fl) mq.delete();
      else begin
        if (m_st == 1) void'(mq.pop_front());
        if (wn && sz < DEPTH) mq.push_back(note_t'(bus.data_in));
      end
      more = mq.size() > 0;
      if (fl) m_st = 0;
      else if (m_st == 0) begin
        if (nen && more) m_st = 1;
      end else if (!nen) m_st = 0;
      else if (m_st == 1) begin
        m_freq = hd.freq; m_units = hd.dur; m_cyc = old_tick;
        if (m_units != 0) m_st = 2;
        else if (more) m_st = 1;
        else begin m_st = 0; m_done = 1; end
      end else begin
        m_cyc--;
        if (m_cyc == 0) begin
          m_units--;
          m_cyc = old_tick;
          if (m_units == 0) begin
            if (more) m_st = 1;
            else begin m_st = 0; m_done = 1; end
          end
        end
      end
      m_rdv = bus.cs_i && bus.read_i;
      m_rda = a;
    end
  end

  function automatic logic [31:0] exp_rd();
    if (!m_rdv) return 32'd0;
    case (m_rda)
      2'd1: return {30'd0, m_ien, m_en};
      2'd2: return {16'd0, 8'(mq.size()), 3'd0, m_st != 0, mq.size() == DEPTH,
                    mq.size() == 0, m_done, m_ovf};
      2'd3: return m_tick;
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      chk("freq_o", freq_o, (m_st == 2) ? m_freq : 0);
      chk("tone_en_o", tone_en_o, (m_st == 2) && (m_freq != 0));
      chk("busy_o", busy_o, m_st != 0);
      chk("irq_o", irq_o, m_ien && m_done);
      chk("data_out", bus.data_out, exp_rd());
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.cs_i = 1; bus.write_i = 1; bus.read_i = 0; bus.address_i = {a, 2'b00}; bus.data_in = d;
    @(negedge clk);
    bus.cs_i = 0; bus.write_i = 0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.cs_i = 1; bus.read_i = 1; bus.write_i = 0; bus.address_i = {a, 2'b00};
    @(negedge clk);
    d = bus.data_out;
    bus.cs_i = 0; bus.read_i = 0;
  endtask

  typedef struct { int f; bit t; int len; } run_t;
  run_t runs[$];

  // Run-length record of {freq_o, tone_en_o} while busy, until busy falls.
  task automatic capture(input string nm, input int maxc);
    bit   seen = 0, fin = 0;
    run_t r;
    runs.delete();
    for (int c = 0; c < maxc && !fin; c++) begin
      if (busy_o) begin
        seen = 1;
        if (runs.size() > 0 && runs[runs.size()-1].f == int'(freq_o) &&
            runs[runs.size()-1].t == tone_en_o) begin
          r = runs[runs.size()-1]; r.len++; runs[runs.size()-1] = r;
        end else begin
          r.f = int'(freq_o); r.t = tone_en_o; r.len = 1; runs.push_back(r);
        end
      end else if (seen) fin = 1;
      if (!fin) @(negedge clk);
    end
    if (!fin) begin
      n_chk++; n_fail++;
      $display("FAIL %s: playback not finished within %0d cycles", nm, maxc);
    end
  endtask

  task automatic chk_run(input string nm, input int i, input int f, input bit t, input int len);
    if (i < runs.size()) begin
      chk({nm, "_freq"}, runs[i].f, f);
      chk({nm, "_tone"}, runs[i].t, t);
      chk({nm, "_len"}, runs[i].len, len);
    end else chk({nm, "_missing"}, runs.size(), i + 1);
  endtask

  task automatic wait_tone(input string nm);
    int k = 0;
    while (!tone_en_o && k < 50) begin @(negedge clk); k++; end
    if (!tone_en_o) begin
      n_chk++; n_fail++;
      $display("FAIL %s: no tone within 50 cycles", nm);
    end
  endtask

  initial begin
    logic [31:0] d;
    int          nt, n55;
    bus.cs_i = 0; bus.read_i = 0; bus.write_i = 0; bus.address_i = 0; bus.data_in = 0;
    repeat (3) @(negedge clk);
    reset = 1;
    chk("rst_freq", freq_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_data", bus.data_out, 0);
    rd(REG_TICK, d);   chk("rst_tick", d, 32'd50000);
    rd(REG_STATUS, d); chk("rst_status", d, 32'h4);

    // single note
    wr(REG_TICK, 4); wr(REG_NOTE, 32'h0003_0010); wr(REG_CTRL, 3);
    capture("single", 100);
    chk("single_runs", runs.size(), 2);
    chk_run("single_gap", 0, 0, 0, 1);
    chk_run("single_tone", 1, 'h10, 1, 12);
    chk("single_irq", irq_o, 1);
    rd(REG_STATUS, d); chk("single_status", d, 32'h6);
    wr(REG_STATUS, 2); chk("single_irq_clr", irq_o, 0);

    // back-to-back with a timed rest
    wr(REG_CTRL, 0); wr(REG_TICK, 2);
    wr(REG_NOTE, 32'h0002_0020); wr(REG_NOTE, 32'h0001_0000); wr(REG_NOTE, 32'h0002_0030);
    wr(REG_CTRL, 1);
    capture("b2b", 100);
    chk("b2b_runs", runs.size(), 4);
    chk_run("b2b_gap", 0, 0, 0, 1);
    chk_run("b2b_n1", 1, 'h20, 1, 4);
    chk_run("b2b_rest", 2, 0, 0, 4);
    chk_run("b2b_n3", 3, 'h30, 1, 4);
    rd(REG_STATUS, d); chk("b2b_done", d, 32'h6);
    wr(REG_STATUS, 2);

    // overflow
    wr(REG_CTRL, 0);
    for (int i = 0; i < DEPTH + 2; i++) wr(REG_NOTE, {16'd1, 16'h100 + 16'(i)});
    rd(REG_STATUS, d); chk("ovf_status", d, 32'h0809);
    wr(REG_TICK, 1); wr(REG_CTRL, 1);
    capture("ovf", 200);
    nt = 0;
    foreach (runs[i]) if (runs[i].t) begin
      chk("ovf_order", runs[i].f, 'h100 + nt);
      chk("ovf_len", runs[i].len, 1);
      nt++;
    end
    chk("ovf_notes", nt, DEPTH);
    wr(REG_STATUS, 3);

    // zero duration is skipped
    wr(REG_CTRL, 0); wr(REG_TICK, 3);
    wr(REG_NOTE, 32'h0000_0055); wr(REG_NOTE, 32'h0001_0011); wr(REG_CTRL, 1);
    capture("zdur", 100);
    n55 = 0;
    foreach (runs[i]) if (runs[i].f == 'h55) n55++;
    chk("zdur_no55", n55, 0);
    chk("zdur_runs", runs.size(), 2);
    chk_run("zdur_gap", 0, 0, 0, 2);
    chk_run("zdur_tone", 1, 'h11, 1, 3);
    wr(REG_STATUS, 2);

    // abort mid-note, then flush
    wr(REG_CTRL, 0); wr(REG_TICK, 2);
    wr(REG_NOTE, 32'h0005_0040); wr(REG_NOTE, 32'h0005_0041); wr(REG_NOTE, 32'h0005_0042);
    wr(REG_CTRL, 1);
    wait_tone("abort_start");
    repeat (2) @(negedge clk);
    wr(REG_CTRL, 0);
    chk("abort_tone", tone_en_o, 0);
    chk("abort_busy", busy_o, 0);
    rd(REG_STATUS, d); chk("abort_status", d, 32'h0200);
    wr(REG_NOTE, 32'h0001_0050);
    wr(REG_CTRL, 4);
    rd(REG_STATUS, d); chk("flush_status", d, 32'h4);

    // reset during PLAY
    wr(REG_NOTE, 32'h0005_0060); wr(REG_CTRL, 1);
    wait_tone("reset_start");
    reset = 0;
    @(negedge clk);
    chk("rstplay_freq", freq_o, 0);
    chk("rstplay_tone", tone_en_o, 0);
    chk("rstplay_busy", busy_o, 0);
    chk("rstplay_irq", irq_o, 0);
    chk("rstplay_data", bus.data_out, 0);
    reset = 1;

    // TICK=0 stored as 1
    wr(REG_TICK, 0);
    rd(REG_TICK, d); chk("tick0_read", d, 1);
    wr(REG_NOTE, 32'h0002_0077); wr(REG_CTRL, 1);
    capture("tick0", 50);
    chk_run("tick0_gap", 0, 0, 0, 1);
    chk_run("tick0_tone", 1, 'h77, 1, 2);

    // push on the LOAD pop cycle
    wr(REG_CTRL, 0);
    wr(REG_NOTE, 32'h0001_0078); wr(REG_NOTE, 32'h0001_0079);
    wr(REG_CTRL, 1);
    wr(REG_NOTE, 32'h0001_007a);
    rd(REG_STATUS, d); chk("pushpop_count", d[15:8], 2);
    capture("pushpop", 50);
    wr(REG_STATUS, 3);

    // randomised traffic, checked every cycle by the model
    wr(REG_CTRL, 1);
    for (int i = 0; i < 3000; i++) begin
      int          op;
      logic [15:0] f;
      op = $urandom_range(0, 99);
      f  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 16'hffff));
      if (op < 30) wr(REG_NOTE, {16'($urandom_range(0, 3)), f});
      else if (op < 40) rd(2'($urandom_range(0, 3)), d);
      else if (op < 45) wr(REG_TICK, $urandom_range(0, 3));
      else if (op < 48) begin
        case ($urandom_range(0, 5))
          0: wr(REG_CTRL, 0);
          1: wr(REG_CTRL, 5);
          2, 3: wr(REG_CTRL, 3);
          default: wr(REG_CTRL, 1);
        endcase
      end else if (op < 52) wr(REG_STATUS, $urandom_range(0, 3));
      else @(negedge clk);
    end
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
